run_step_ctrl: RTL and testbench
================================

// Module: run_step_ctrl
// PURPOSE
//  Run/stop/single-step controller for the MIPS board clocking path. Debounces
//  the run and step pushbuttons and watches the processor halt instruction.
//  Drives the clock divider's halt and setFreq inputs, so it sits directly
//  upstream of the divider. Watches the divided clock (tick_in) so that a step
//  lasts exactly one slow-clock rising edge.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles needed to accept a button level
//  DB_W             16     debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  reset       in   1  synchronous, active-low reset
//  btn_run     in   1  raw async pushbutton; each press toggles run/stop
//  btn_step    in   1  raw async pushbutton; each press requests one slow-clock cycle
//  sw_fast     in   1  raw async switch; 1 = fast clock mode
//  cpu_halt    in   1  processor decoded HALT instruction, level, clk domain
//  tick_in     in   1  divided clock level from the clock divider
//  halt        out  1  to divider halt; 1 = slow clock frozen
//  set_freq    out  1  to divider setFreq; synchronized sw_fast
//  state       out  2  0=STOPPED 1=RUNNING 2=STEPPING 3=HALTED
//  step_count  out  8  number of completed steps, wraps 255->0
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=STOPPED, halt=1, set_freq=0, step_count=0.
//   Clears synchronizers, debounce counters, stable levels and tick_prev.
//  Synchronizers: two-flop chain on btn_run, btn_step, sw_fast and tick_in.
//   set_freq = sw_fast after the 2-flop chain; it lags the switch by 2 cycles.
//  Debounce, per button:
//   - If the synced level equals the stable level, the counter clears.
//   - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the
//     stable level flips and the counter clears.
//   - A press is a 1-cycle pulse on a stable 0->1 transition.
//   - Releases generate nothing.
//   - Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles.
//  tick_rise = tick_sync & ~tick_prev; tick_prev is registered every cycle.
//  FSM (registered; priority listed top-down):
//   STOPPED:  run_press -> RUNNING; else step_press -> STEPPING.
//   RUNNING:  cpu_halt -> HALTED; else run_press -> STOPPED; step_press ignored.
//   STEPPING: cpu_halt -> HALTED;
//             else tick_rise -> STOPPED and step_count+1 (mod 256);
//             run_press and step_press ignored.
//   HALTED:   absorbing; only reset exits; all inputs ignored.
//  halt = 1 in STOPPED/HALTED, 0 in RUNNING/STEPPING; decoded from registered state.
//   So halt changes in the cycle after the qualifying event.
//  step_count changes only on the STEPPING->STOPPED transition, never on HALTED.
//  A tick_rise in STOPPED or RUNNING has no effect.
//  Reset mid-operation wins over every event in the same cycle.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 reset=0 for 2 cycles with all inputs 1 -> state=0, halt=1, set_freq=0, step_count=0.
//  2 btn_run bounces 1,0,1 (1 cycle each), then low -> state stays 0.
//    btn_run held 10 cycles -> state=1, halt=0, exactly one transition.
//    Release, press again -> state=0.
//  3 STOPPED, step press, then tick_in 0->1 five cycles later:
//    - halt=0 until 3 cycles after the tick edge, then state=0, step_count=1.
//    - 256 steps total -> step_count=0.
//  4 RUNNING, cpu_halt high 1 cycle -> state=3, halt=1.
//    Run and step presses leave state=3; reset -> state=0.
//  5 Simultaneous events:
//    - cpu_halt with run_press in RUNNING -> 3.
//    - run_press with step_press in STOPPED -> 1.
//    - cpu_halt with tick_rise in STEPPING -> 3, step_count unchanged.
//  6 reset=0 mid-STEPPING -> state=0, step_count=0.
//    sw_fast 0->1 -> set_freq=1 exactly 2 cycles later.

Source files
------------

// File: rtl/run_step_ctrl.sv
// Run/stop/single-step controller sitting upstream of the board clock divider.
// Debounces the run/step buttons, tracks CPU HALT and counts completed steps.

module run_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            stable_q;
    logic            press_q;
    logic [DB_W-1:0] cnt_q;

    // press_q fires only on an accepted 0->1 change of the stable level
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            press_q <= 1'b0;
            if (s2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= s2_q;
                press_q  <= s2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

    assign press_o = press_q;
endmodule

module run_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       sw_fast,
    input  logic       cpu_halt,
    input  logic       tick_in,
    output logic       halt,
    output logic       set_freq,
    output logic [1:0] state,
    output logic [7:0] step_count
);
    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t     state_q;
    logic       halt_q;
    logic [7:0] count_q;
    logic       fast_s1_q;
    logic       fast_s2_q;
    logic       tick_s1_q;
    logic       tick_s2_q;
    logic       tick_prev_q;
    logic       run_press;
    logic       step_press;
    logic       tick_rise;

    run_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_run (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_run),
        .press_o (run_press)
    );

    run_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_step (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_step),
        .press_o (step_press)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fast_s1_q   <= 1'b0;
            fast_s2_q   <= 1'b0;
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_prev_q <= 1'b0;
        end else begin
            fast_s1_q   <= sw_fast;
            fast_s2_q   <= fast_s1_q;
            tick_s1_q   <= tick_in;
            tick_s2_q   <= tick_s1_q;
            tick_prev_q <= tick_s2_q;
        end
    end

    assign tick_rise = tick_s2_q & ~tick_prev_q;

    // halt_q is loaded with the decode of the next state, so it always
    // matches state_q and moves one cycle after the qualifying event
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_STOPPED;
            halt_q  <= 1'b1;
            count_q <= 8'd0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (run_press) begin
                        state_q <= ST_RUNNING;
                        halt_q  <= 1'b0;
                    end else if (step_press) begin
                        state_q <= ST_STEPPING;
                        halt_q  <= 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (cpu_halt) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end else if (run_press) begin
                        state_q <= ST_STOPPED;
                        halt_q  <= 1'b1;
                    end
                end
                ST_STEPPING: begin
                    if (cpu_halt) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end else if (tick_rise) begin
                        state_q <= ST_STOPPED;
                        halt_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                    halt_q  <= 1'b1;
                end
            endcase
        end
    end

    assign halt       = halt_q;
    assign set_freq   = fast_s2_q;
    assign state      = state_q;
    assign step_count = count_q;
endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed bench for run_step_ctrl with a short debounce window.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_run_step_ctrl;
    localparam int DBC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run;
    logic       btn_step;
    logic       sw_fast;
    logic       cpu_halt;
    logic       tick_in;
    logic       halt;
    logic       set_freq;
    logic [1:0] state;
    logic [7:0] step_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_step_ctrl #(.DEBOUNCE_CYCLES(DBC), .DB_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .sw_fast    (sw_fast),
        .cpu_halt   (cpu_halt),
        .tick_in    (tick_in),
        .halt       (halt),
        .set_freq   (set_freq),
        .state      (state),
        .step_count (step_count)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic press_run();
        btn_run = 1'b1;
        cyc(10);
        btn_run = 1'b0;
        cyc(10);
    endtask

    task automatic press_step();
        btn_step = 1'b1;
        cyc(10);
        btn_step = 1'b0;
        cyc(10);
    endtask

    task automatic do_step();
        int k;
        k = 0;
        btn_step = 1'b1;
        while (state !== 2'd2 && k < 15) begin cyc(1); k++; end
        btn_step = 1'b0;
        n_cmp++;
        if (state !== 2'd2) begin n_bad++; $display("FAIL do_step_enter: state=%0d want 2", state); end
        cyc(5);
        tick_in = 1'b1;
        k = 0;
        while (state !== 2'd0 && k < 10) begin cyc(1); k++; end
        n_cmp++;
        if (state !== 2'd0) begin n_bad++; $display("FAIL do_step_exit: state=%0d want 0", state); end
        tick_in = 1'b0;
        cyc(8);
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_run = 1'b1; btn_step = 1'b1; sw_fast = 1'b1;
        cpu_halt = 1'b1; tick_in = 1'b1;
        cyc(2);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL reset_halt: got %b want 1", halt); end
        n_cmp++; if (set_freq !== 1'b0) begin n_bad++; $display("FAIL reset_set_freq: got %b want 0", set_freq); end
        n_cmp++; if (step_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", step_count); end
        reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0; sw_fast = 1'b0;
        cpu_halt = 1'b0; tick_in = 1'b0;
        cyc(2);
    endtask

    task automatic test_debounce_run();
        logic [1:0] prev;
        int trans;
        btn_run = 1'b1; cyc(1);
        btn_run = 1'b0; cyc(1);
        btn_run = 1'b1; cyc(1);
        btn_run = 1'b0; cyc(10);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL bounce_ignored: state=%0d want 0", state); end
        btn_run = 1'b1;
        cyc(6);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL run_latency_early: state=%0d want 0", state); end
        prev = state;
        trans = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (state !== prev) trans++;
            prev = state;
        end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL run_press_state: got %0d want 1", state); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL run_press_halt: got %b want 0", halt); end
        n_cmp++; if (trans !== 1) begin n_bad++; $display("FAIL run_single_transition: got %0d want 1", trans); end
        btn_run = 1'b0;
        cyc(10);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL release_ignored: state=%0d want 1", state); end
        press_run();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL run_toggle_stop: state=%0d want 0", state); end
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL run_toggle_halt: got %b want 1", halt); end
    endtask

    task automatic test_step();
        int k;
        k = 0;
        btn_step = 1'b1;
        while (state !== 2'd2 && k < 15) begin cyc(1); k++; end
        btn_step = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL step_enter: state=%0d want 2", state); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL step_enter_halt: got %b want 0", halt); end
        cyc(5);
        tick_in = 1'b1;
        cyc(1);
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL step_halt_t1: got %b want 0", halt); end
        cyc(1);
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL step_halt_t2: got %b want 0", halt); end
        n_cmp++; if (step_count !== 8'd0) begin n_bad++; $display("FAIL step_count_early: got %0d want 0", step_count); end
        cyc(1);
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL step_halt_t3: got %b want 1", halt); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL step_done_state: got %0d want 0", state); end
        n_cmp++; if (step_count !== 8'd1) begin n_bad++; $display("FAIL step_count_one: got %0d want 1", step_count); end
        tick_in = 1'b0;
        cyc(8);
        for (int i = 0; i < 255; i++) do_step();
        n_cmp++; if (step_count !== 8'd0) begin n_bad++; $display("FAIL step_count_wrap: got %0d want 0", step_count); end
    endtask

    task automatic test_halt();
        press_run();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL halt_pre_running: state=%0d want 1", state); end
        cpu_halt = 1'b1;
        cyc(1);
        cpu_halt = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL halt_state: got %0d want 3", state); end
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_out: got %b want 1", halt); end
        press_run();
        press_step();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL halt_absorbing: state=%0d want 3", state); end
        pulse_reset();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL halt_reset_exit: state=%0d want 0", state); end
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_reset_halt: got %b want 1", halt); end
    endtask

    task automatic test_simultaneous();
        int k;
        press_run();
        btn_run = 1'b1;
        cyc(6);
        cpu_halt = 1'b1;
        cyc(1);
        cpu_halt = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL sim_halt_vs_run: state=%0d want 3", state); end
        btn_run = 1'b0;
        cyc(10);
        pulse_reset();
        btn_run = 1'b1; btn_step = 1'b1;
        cyc(10);
        btn_run = 1'b0; btn_step = 1'b0;
        cyc(10);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL sim_run_vs_step: state=%0d want 1", state); end
        press_run();
        k = 0;
        btn_step = 1'b1;
        while (state !== 2'd2 && k < 15) begin cyc(1); k++; end
        btn_step = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL sim_step_enter: state=%0d want 2", state); end
        cyc(5);
        tick_in = 1'b1;
        cyc(2);
        cpu_halt = 1'b1;
        cyc(1);
        cpu_halt = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL sim_halt_vs_tick: state=%0d want 3", state); end
        n_cmp++; if (step_count !== 8'd0) begin n_bad++; $display("FAIL sim_halt_count: got %0d want 0", step_count); end
        tick_in = 1'b0;
        cyc(4);
        pulse_reset();
    endtask

    task automatic test_reset_mid_and_fast();
        int k;
        do_step();
        n_cmp++; if (step_count !== 8'd1) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 1", step_count); end
        k = 0;
        btn_step = 1'b1;
        while (state !== 2'd2 && k < 15) begin cyc(1); k++; end
        btn_step = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mid_step_enter: state=%0d want 2", state); end
        reset = 1'b0;
        tick_in = 1'b1;
        cyc(1);
        reset = 1'b1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", state); end
        n_cmp++; if (step_count !== 8'd0) begin n_bad++; $display("FAIL mid_reset_count: got %0d want 0", step_count); end
        cyc(4);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_tick_in_stopped: state=%0d want 0", state); end
        tick_in = 1'b0;
        cyc(4);
        sw_fast = 1'b1;
        cyc(1);
        n_cmp++; if (set_freq !== 1'b0) begin n_bad++; $display("FAIL fast_lag_1: got %b want 0", set_freq); end
        cyc(1);
        n_cmp++; if (set_freq !== 1'b1) begin n_bad++; $display("FAIL fast_lag_2: got %b want 1", set_freq); end
    endtask

    initial begin
        test_reset();
        test_debounce_run();
        test_step();
        test_halt();
        test_simultaneous();
        test_reset_mid_and_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, state=%0d", state);
        $fatal(1, "watchdog");
    end
endmodule
